regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: Alu_valid  input  1  ALU result valid this cycle.
REQ-004 SHALL have port: Alu_rd  input  5  ALU destination register.
REQ-005 SHALL have port: Alu_data  input  32  ALU result.
REQ-006 SHALL have port: Ld_issue  input  1  load issued this cycle; marks destination pending.
REQ-007 SHALL have port: Ld_issue_rd  input  5  destination of issued load.
REQ-008 SHALL have port: Ld_valid  input  1  load data returning this cycle.
REQ-009 SHALL have port: Ld_rd  input  5  destination of returning load.
REQ-010 SHALL have port: Ld_data  input  32  returning load data.
REQ-011 SHALL have port: Ld_ready  output  1  load buffer can accept (count < 4), combinational from count.
REQ-012 SHALL have port: Wen  output  1  register-file write enable, registered.
REQ-013 SHALL have port: Wnum  output  5  register-file write index, registered.
REQ-014 SHALL have port: Wd  output  32  register-file write data, registered.
REQ-015 SHALL have port: Busy  output  32  per-register pending-load scoreboard; bit 0 constant 0.
REQ-016 SHALL have port: Err  output  1  sticky overflow flag.

Function
REQ-017 SHALL hold a 4-entry in-order load FIFO (rd + data) with 3-bit count.
REQ-018 Per cycle, the selected writeback SHALL be: ALU if Alu_valid; else FIFO head if count>0 (pop); else Ld input if Ld_valid (bypass, no push); else none.
REQ-019 Ld_valid with Ld_ready=1 SHALL push into FIFO unless consumed by bypass per REQ-018.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-021 Ld_valid with Ld_ready=0 SHALL be dropped and SHALL set Err=1 until reset.
REQ-022 Selected writeback SHALL appear on Wen/Wnum/Wd at the next rising edge (latency 1); Wen SHALL be 1 for exactly one cycle per write.
REQ-023 Selected writeback with rd=0 SHALL be consumed but SHALL drive Wen=0.
REQ-024 No selection SHALL drive Wen=0; Wnum/Wd SHALL hold previous values.
REQ-025 Ld_issue with Ld_issue_rd!=0 SHALL set Busy[Ld_issue_rd] at the next edge.
REQ-026 A selected load writeback (FIFO pop or bypass) SHALL clear Busy[rd] at the same edge Wen rises.
REQ-027 Set and clear of the same index in one cycle: set SHALL win.
REQ-028 ALU writebacks SHALL NOT modify Busy.
REQ-029 Loads SHALL reach the register file in arrival order; ALU writes may overtake buffered loads.

Reset
REQ-030 rst_n=0 SHALL immediately force Wen=0, Wnum=0, Wd=0, Busy=0, Err=0, count=0, Ld_ready=1, independent of clk.
REQ-031 Reset mid-operation SHALL discard all FIFO contents and pending Busy bits; no write SHALL issue on the first edge after release.

Verification
REQ-032 Bypass: idle, Ld_issue rd=5, then Ld_valid rd=5 data=0xDEADBEEF -> next cycle Wen=1 Wnum=5 Wd=0xDEADBEEF; Busy[5] 1 then 0.
REQ-033 Priority: Alu_valid rd=3 data=0x11 held 3 cycles with Ld_valid rd=7 data=0x22 on cycle 1 -> three ALU writes to x3, then Wnum=7 Wd=0x22 on cycle 5.
REQ-034 Full/overflow: Alu_valid held, 5 loads rd=1..5 back-to-back -> Ld_ready=0 after 4th, 5th dropped, Err=1; release ALU -> writes x1..x4 in order.
REQ-035 x0: Alu_valid rd=0 data=0xFFFFFFFF and Ld_issue rd=0 -> Wen stays 0, Busy stays 0.
REQ-036 Set-wins: Busy[9]=1, same cycle FIFO pops rd=9 and Ld_issue rd=9 -> Wen=1 Wnum=9, Busy[9] remains 1.
REQ-037 Async reset: assert rst_n=0 mid-cycle with count=3 -> outputs zero before next edge; after release Ld_ready=1, no stale writes.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority, returning loads
// are either bypassed straight to the write port or buffered in a 4-entry
// in-order FIFO. A per-register scoreboard tracks loads that are still pending.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Alu_valid,
  input  logic [4:0]  Alu_rd,
  input  logic [31:0] Alu_data,
  input  logic        Ld_issue,
  input  logic [4:0]  Ld_issue_rd,
  input  logic        Ld_valid,
  input  logic [4:0]  Ld_rd,
  input  logic [31:0] Ld_data,
  output logic        Ld_ready,
  output logic        Wen,
  output logic [4:0]  Wnum,
  output logic [31:0] Wd,
  output logic [31:0] Busy,
  output logic        Err
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REGS   = 32;

  logic [RD_W-1:0]   fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              sel_valid;
  logic              sel_load;
  logic [RD_W-1:0]   sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              pop;
  logic              bypass;
  logic              push;
  logic              drop;
  logic [REGS-1:0]   busy_set;
  logic [REGS-1:0]   busy_clr;

  // Space is judged on the current occupancy only, so a full FIFO refuses a
  // load even in a cycle where it also pops.
  assign Ld_ready = (count < CNT_W'(DEPTH));

  // Writeback source priority: ALU, then oldest buffered load, then bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (Alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = Alu_rd;
      sel_data  = Alu_data;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
      pop       = 1'b1;
    end else if (Ld_valid) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = Ld_rd;
      sel_data  = Ld_data;
      bypass    = 1'b1;
    end
  end

  assign push = Ld_valid && Ld_ready && !bypass;
  assign drop = Ld_valid && !Ld_ready;

  // Scoreboard set/clear masks; register 0 never becomes busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (Ld_issue && (Ld_issue_rd != '0)) busy_set[Ld_issue_rd] = 1'b1;
    if (sel_load) busy_clr[sel_rd] = 1'b1;
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= Ld_rd;
      fifo_data[wr_ptr] <= Ld_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; index/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Wen  <= 1'b0;
      Wnum <= '0;
      Wd   <= '0;
    end else begin
      Wen <= sel_valid && (sel_rd != '0);
      if (sel_valid && (sel_rd != '0)) begin
        Wnum <= sel_rd;
        Wd   <= sel_data;
      end
    end
  end

  // Pending-load scoreboard (set beats clear) and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Busy <= '0;
      Err  <= 1'b0;
    end else begin
      Busy <= ((Busy & ~busy_clr) | busy_set) & ~REGS'(1);
      if (drop) Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        Alu_valid;
  logic [4:0]  Alu_rd;
  logic [31:0] Alu_data;
  logic        Ld_issue;
  logic [4:0]  Ld_issue_rd;
  logic        Ld_valid;
  logic [4:0]  Ld_rd;
  logic [31:0] Ld_data;
  logic        Ld_ready;
  logic        Wen;
  logic [4:0]  Wnum;
  logic [31:0] Wd;
  logic [31:0] Busy;
  logic        Err;

  int vectors;
  int miscompares;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .Alu_valid(Alu_valid), .Alu_rd(Alu_rd), .Alu_data(Alu_data),
    .Ld_issue(Ld_issue), .Ld_issue_rd(Ld_issue_rd),
    .Ld_valid(Ld_valid), .Ld_rd(Ld_rd), .Ld_data(Ld_data),
    .Ld_ready(Ld_ready), .Wen(Wen), .Wnum(Wnum), .Wd(Wd),
    .Busy(Busy), .Err(Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Alu_valid = 1'b0; Alu_rd = '0; Alu_data = '0;
    Ld_issue = 1'b0; Ld_issue_rd = '0;
    Ld_valid = 1'b0; Ld_rd = '0; Ld_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    vectors++;
    if (Wen !== 1'b0 || Wnum !== 5'd0 || Wd !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_wport: Wen=%b Wnum=%0d Wd=%h, required 0/0/0", Wen, Wnum, Wd);
    end
    vectors++;
    if (Busy !== 32'd0 || Err !== 1'b0 || Ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: Busy=%h Err=%b Ld_ready=%b, required 0/0/1", Busy, Err, Ld_ready);
    end
    #4 rst_n = 1'b1;
    tick();
    vectors++;
    if (Wen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: Wen=%b, required 0", Wen);
    end
  endtask

  task automatic test_bypass();
    Ld_issue = 1'b1; Ld_issue_rd = 5'd5;
    tick();
    vectors++;
    if (Busy !== 32'h0000_0020 || Wen !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_issue: Busy=%h Wen=%b, required 00000020/0", Busy, Wen);
    end
    Ld_issue = 1'b0; Ld_issue_rd = '0;
    Ld_valid = 1'b1; Ld_rd = 5'd5; Ld_data = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if (Wen !== 1'b1 || Wnum !== 5'd5 || Wd !== 32'hDEAD_BEEF || Busy !== 32'd0) begin
      miscompares++;
      $display("FAIL bypass_write: Wen=%b Wnum=%0d Wd=%h Busy=%h, required 1/5/deadbeef/0",
               Wen, Wnum, Wd, Busy);
    end
    idle_inputs();
    tick();
    vectors++;
    if (Wen !== 1'b0 || Wnum !== 5'd5 || Wd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_hold: Wen=%b Wnum=%0d Wd=%h, required 0/5/deadbeef", Wen, Wnum, Wd);
    end
  endtask

  task automatic test_priority();
    Alu_valid = 1'b1; Alu_rd = 5'd3; Alu_data = 32'h11;
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) begin
        Ld_valid = 1'b1; Ld_rd = 5'd7; Ld_data = 32'h22;
      end else begin
        Ld_valid = 1'b0; Ld_rd = '0; Ld_data = '0;
      end
      tick();
      vectors++;
      if (Wen !== 1'b1 || Wnum !== 5'd3 || Wd !== 32'h11) begin
        miscompares++;
        $display("FAIL prio_alu%0d: Wen=%b Wnum=%0d Wd=%h, required 1/3/11", c, Wen, Wnum, Wd);
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if (Wen !== 1'b1 || Wnum !== 5'd7 || Wd !== 32'h22) begin
      miscompares++;
      $display("FAIL prio_load: Wen=%b Wnum=%0d Wd=%h, required 1/7/22", Wen, Wnum, Wd);
    end
    tick();
    vectors++;
    if (Wen !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_drain: Wen=%b, required 0", Wen);
    end
  endtask

  task automatic test_overflow();
    Alu_valid = 1'b1; Alu_rd = 5'd10; Alu_data = 32'hA;
    for (int i = 1; i <= 5; i++) begin
      Ld_valid = 1'b1; Ld_rd = 5'(i); Ld_data = 32'h100 + 32'(i);
      tick();
      if (i == 4) begin
        vectors++;
        if (Ld_ready !== 1'b0 || Err !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_full: Ld_ready=%b Err=%b, required 0/0", Ld_ready, Err);
        end
      end
    end
    vectors++;
    if (Err !== 1'b1 || Wnum !== 5'd10) begin
      miscompares++;
      $display("FAIL ovf_err: Err=%b Wnum=%0d, required 1/10", Err, Wnum);
    end
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (Wen !== 1'b1 || Wnum !== 5'(i) || Wd !== 32'h100 + 32'(i) || Ld_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_drain%0d: Wen=%b Wnum=%0d Wd=%h Ld_ready=%b, required 1/%0d/%h/1",
                 i, Wen, Wnum, Wd, Ld_ready, i, 32'h100 + 32'(i));
      end
    end
    tick();
    vectors++;
    if (Wen !== 1'b0 || Err !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_empty: Wen=%b Err=%b, required 0/1", Wen, Err);
    end
  endtask

  task automatic test_x0();
    Alu_valid = 1'b1; Alu_rd = 5'd0; Alu_data = 32'hFFFF_FFFF;
    Ld_issue = 1'b1; Ld_issue_rd = 5'd0;
    tick();
    vectors++;
    if (Wen !== 1'b0 || Busy !== 32'd0 || Wd !== 32'h104) begin
      miscompares++;
      $display("FAIL x0_write: Wen=%b Busy=%h Wd=%h, required 0/0/104", Wen, Busy, Wd);
    end
    idle_inputs();
  endtask

  task automatic test_set_wins();
    Alu_valid = 1'b1; Alu_rd = 5'd2; Alu_data = 32'h22;
    Ld_issue = 1'b1; Ld_issue_rd = 5'd9;
    Ld_valid = 1'b1; Ld_rd = 5'd9; Ld_data = 32'h99;
    tick();
    vectors++;
    if (Busy !== 32'h0000_0200 || Wnum !== 5'd2) begin
      miscompares++;
      $display("FAIL setwin_prep: Busy=%h Wnum=%0d, required 00000200/2", Busy, Wnum);
    end
    idle_inputs();
    Ld_issue = 1'b1; Ld_issue_rd = 5'd9;
    tick();
    vectors++;
    if (Wen !== 1'b1 || Wnum !== 5'd9 || Wd !== 32'h99 || Busy !== 32'h0000_0200) begin
      miscompares++;
      $display("FAIL setwin_pop: Wen=%b Wnum=%0d Wd=%h Busy=%h, required 1/9/99/00000200",
               Wen, Wnum, Wd, Busy);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    Alu_valid = 1'b1; Alu_rd = 5'd4; Alu_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      Ld_valid = 1'b1; Ld_rd = 5'(11 + i); Ld_data = 32'h200 + 32'(i);
      Ld_issue = 1'b1; Ld_issue_rd = 5'(11 + i);
      tick();
    end
    vectors++;
    if (Wen !== 1'b1 || Wnum !== 5'd4 || Busy !== 32'h0000_3A00 || Err !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_prep: Wen=%b Wnum=%0d Busy=%h Err=%b, required 1/4/00003a00/1",
               Wen, Wnum, Busy, Err);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (Wen !== 1'b0 || Wnum !== 5'd0 || Wd !== 32'd0 || Busy !== 32'd0 ||
        Err !== 1'b0 || Ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_now: Wen=%b Wnum=%0d Wd=%h Busy=%h Err=%b Ld_ready=%b, required zeros, Ld_ready=1",
               Wen, Wnum, Wd, Busy, Err, Ld_ready);
    end
    idle_inputs();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (Wen !== 1'b0 || Ld_ready !== 1'b1 || Busy !== 32'd0) begin
        miscompares++;
        $display("FAIL areset_stale%0d: Wen=%b Ld_ready=%b Busy=%h, required 0/1/0",
                 i, Wen, Ld_ready, Busy);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_bypass();
    test_priority();
    test_overflow();
    test_x0();
    test_set_wins();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
